axi_lite_write_master: RTL and testbench
========================================

Name: axi_lite_write_master

Overview:
AXI4-Lite write initiator: the master end of the write-only register bus our peripherals (e.g. the PWM block) expose as slaves. Accepts one {addr, data} command on a valid/ready port, drives AW and W concurrently, collects the B response and reports it with an optional response timeout. Placed between a config sequencer/CPU-less controller and any AXI-Lite write slave.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/axi_lite_awaddr
DATA_WIDTH, 32, width of cmd_data/axi_lite_wdata
TIMEOUT_CYCLES, 256, cycles from AW/W issue to B handshake before abort; 0 = timeout disabled
CNT_WIDTH, 16, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
axi_lite_aclk  in  1  clock; all logic on rising edge
axi_lite_aresetn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready
cmd_addr  in  ADDR_WIDTH  write address
cmd_data  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_resp  out  2  captured BRESP, or 2'b10 on timeout; held until next rsp_valid
rsp_timeout  out  1  1 with rsp_valid when aborted by timeout; held like rsp_resp
axi_lite_awaddr  out  ADDR_WIDTH  write address
axi_lite_awvalid  out  1
axi_lite_awready  in  1
axi_lite_wdata  out  DATA_WIDTH  write data
axi_lite_wvalid  out  1
axi_lite_wready  in  1
axi_lite_bresp  in  2
axi_lite_bvalid  in  1
axi_lite_bready  out  1

Behaviour:
- All outputs registered. Reset (async assert, sync release): cmd_ready=0, awvalid=wvalid=bready=0, awaddr=wdata=0, rsp_valid=0, rsp_resp=2'b00, rsp_timeout=0, counter=0, state IDLE. cmd_ready rises on first clock edge after release.
- States: IDLE, ADDR_DATA, RESP, DONE.
- IDLE: cmd_ready=1. Edge with cmd_valid&cmd_ready: latch awaddr/wdata, awvalid=wvalid=1, cmd_ready=0, counter=0 -> ADDR_DATA. cmd_valid while cmd_ready=0 ignored (no queue).
- ADDR_DATA: AW and W independent. awvalid clears on edge sampling awready=1; wvalid clears on edge sampling wready=1; either order or same edge. awaddr/wdata stable while their valid is high. When both handshakes complete (incl. same edge) -> RESP, bready=1 next cycle.
- RESP: bready=1. Edge with bvalid&bready: rsp_resp<=bresp, rsp_timeout<=0, bready=0 -> DONE. bvalid arriving before RESP is not acknowledged until RESP.
- DONE: rsp_valid=1 one cycle, cmd_ready=1 same cycle -> IDLE. Min latency cmd accept to rsp_valid with always-ready slave: 4 edges (issue, AW/W hs, B hs, DONE).
- Timeout: counter increments every cycle in ADDR_DATA and RESP; saturates. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without B handshake: awvalid=wvalid=bready=0, rsp_resp<=2'b10, rsp_timeout<=1 -> DONE. Recovery-only abort (valid dropped without handshake); slave state afterwards undefined. A handshake on the same edge as timeout wins (normal completion).
- BRESP passed through unchanged (OKAY/EXOKAY/SLVERR/DECERR).
- Reset mid-transaction: all valids/bready drop immediately; no rsp_valid generated for aborted command.

Test Plan:
- Always-ready slave, cmd addr=0x0 data=0x02E90EDD -> awvalid&wvalid high exactly 1 cycle with those values, bready 1 cycle, rsp_valid 4 edges after accept, rsp_resp=00, rsp_timeout=0.
- awready delayed 3 cycles, wready immediate, addr=0x4 data=10 -> wvalid 1 cycle, awvalid 4 cycles, awaddr stable, single B handshake, rsp_resp=00.
- wready delayed 5, awready delayed 2, bvalid with bresp=2'b10 after 2 more cycles -> rsp_resp=10, rsp_timeout=0; cmd_valid pulses during transaction ignored (only one AW issued).
- TIMEOUT_CYCLES=16, slave handshakes AW/W but never asserts bvalid -> bready drops and rsp_valid with rsp_resp=10, rsp_timeout=1 on 16th cycle after issue; next cmd (addr=0xC data=5000) completes normally with rsp_timeout=0.
- aresetn low while awvalid=1 -> awvalid/wvalid/bready 0 asynchronously, no rsp_valid; after release cmd_ready=1 next edge, write addr=0x8 data=10000 completes OKAY.

Source files
------------

// File: rtl/axi_lite_write_master.sv
// AXI4-Lite write initiator: takes one {addr, data} command, issues AW and W
// concurrently, collects the B response and reports it, with an optional response timeout.
module axi_lite_write_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  axi_lite_aclk,
    input  logic                  axi_lite_aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,

    output logic                  rsp_valid,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] axi_lite_awaddr,
    output logic                  axi_lite_awvalid,
    input  logic                  axi_lite_awready,
    output logic [DATA_WIDTH-1:0] axi_lite_wdata,
    output logic                  axi_lite_wvalid,
    input  logic                  axi_lite_wready,
    input  logic [1:0]            axi_lite_bresp,
    input  logic                  axi_lite_bvalid,
    output logic                  axi_lite_bready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP,
        DONE
    } state_t;

    localparam logic                 TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT =
        (TIMEOUT_CYCLES == 0) ? {CNT_WIDTH{1'b0}} : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]           RESP_SLVERR   = 2'b10;

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic                 aw_done;
    logic                 w_done;
    logic                 expired;

    // A channel counts as finished once its valid is already low or is handshaking now.
    assign aw_done = !axi_lite_awvalid || axi_lite_awready;
    assign w_done  = !axi_lite_wvalid  || axi_lite_wready;
    assign expired = TIMEOUT_EN && (counter >= TIMEOUT_LIMIT);

    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            state            <= IDLE;
            counter          <= '0;
            cmd_ready        <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_resp         <= 2'b00;
            rsp_timeout      <= 1'b0;
            axi_lite_awaddr  <= '0;
            axi_lite_awvalid <= 1'b0;
            axi_lite_wdata   <= '0;
            axi_lite_wvalid  <= 1'b0;
            axi_lite_bready  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        axi_lite_awaddr  <= cmd_addr;
                        axi_lite_wdata   <= cmd_data;
                        axi_lite_awvalid <= 1'b1;
                        axi_lite_wvalid  <= 1'b1;
                        cmd_ready        <= 1'b0;
                        counter          <= '0;
                        state            <= ADDR_DATA;
                    end
                end

                ADDR_DATA: begin
                    if (counter != {CNT_WIDTH{1'b1}}) begin
                        counter <= counter + CNT_WIDTH'(1);
                    end
                    if (axi_lite_awready) begin
                        axi_lite_awvalid <= 1'b0;
                    end
                    if (axi_lite_wready) begin
                        axi_lite_wvalid <= 1'b0;
                    end
                    // Finishing both handshakes on the expiry edge takes priority over the abort.
                    if (aw_done && w_done) begin
                        axi_lite_bready <= 1'b1;
                        state           <= RESP;
                    end else if (expired) begin
                        axi_lite_awvalid <= 1'b0;
                        axi_lite_wvalid  <= 1'b0;
                        rsp_resp         <= RESP_SLVERR;
                        rsp_timeout      <= 1'b1;
                        state            <= DONE;
                    end
                end

                RESP: begin
                    if (counter != {CNT_WIDTH{1'b1}}) begin
                        counter <= counter + CNT_WIDTH'(1);
                    end
                    if (axi_lite_bvalid) begin
                        rsp_resp        <= axi_lite_bresp;
                        rsp_timeout     <= 1'b0;
                        axi_lite_bready <= 1'b0;
                        state           <= DONE;
                    end else if (expired) begin
                        axi_lite_bready <= 1'b0;
                        rsp_resp        <= RESP_SLVERR;
                        rsp_timeout     <= 1'b1;
                        state           <= DONE;
                    end
                end

                DONE: begin
                    rsp_valid <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Self-checking bench for axi_lite_write_master: a delay-configurable AXI-Lite slave
// plus scoreboard queues of expected AW/W beats and responses.
module tb_axi_lite_write_master;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [1:0] resp;
        logic       timeout;
        int         latency;
    } rsp_item_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    int         check_count = 0;
    int         pass_count  = 0;
    int         edge_count  = 0;
    int         accept_edge = 0;

    int         aw_delay = 0;
    int         w_delay  = 0;
    int         b_delay  = 0;
    bit         b_never  = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    int         aw_cnt = 0;
    int         w_cnt  = 0;
    int         b_cnt  = 0;

    int aw_cycles = 0;
    int w_cycles  = 0;
    int bready_cycles = 0;
    int aw_hs_count = 0;
    int w_hs_count  = 0;
    int b_hs_count  = 0;

    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    rsp_item_t     rsp_q[$];

    axi_lite_write_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_WIDTH     (16)
    ) dut (
        .axi_lite_aclk   (clk),
        .axi_lite_aresetn(rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_resp        (rsp_resp),
        .rsp_timeout     (rsp_timeout),
        .axi_lite_awaddr (awaddr),
        .axi_lite_awvalid(awvalid),
        .axi_lite_awready(awready),
        .axi_lite_wdata  (wdata),
        .axi_lite_wvalid (wvalid),
        .axi_lite_wready (wready),
        .axi_lite_bresp  (bresp),
        .axi_lite_bvalid (bvalid),
        .axi_lite_bready (bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            edge_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, edge_count);
        end
    endtask

    // Slave and monitor share the falling edge: DUT outputs are stable here, and the
    // ready/valid driven now is what the DUT samples at the following rising edge.
    initial begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                awready = (aw_cnt >= aw_delay);
                aw_cnt++;
            end else begin
                awready = 1'b0;
                aw_cnt  = 0;
            end
            if (wvalid) begin
                wready = (w_cnt >= w_delay);
                w_cnt++;
            end else begin
                wready = 1'b0;
                w_cnt  = 0;
            end
            if (bready) begin
                bvalid = !b_never && (b_cnt >= b_delay);
                bresp  = b_resp_cfg;
                b_cnt++;
            end else begin
                bvalid = 1'b0;
                b_cnt  = 0;
            end

            if (awvalid) begin
                aw_cycles++;
                if (aw_q.size() == 0) begin
                    checkOutput("aw_unexpected", 64'(aw_q.size()), 64'd1);
                end else begin
                    checkOutput("awaddr", 64'(awaddr), 64'(aw_q[0]));
                    if (awready) begin
                        void'(aw_q.pop_front());
                        aw_hs_count++;
                    end
                end
            end
            if (wvalid) begin
                w_cycles++;
                if (w_q.size() == 0) begin
                    checkOutput("w_unexpected", 64'(w_q.size()), 64'd1);
                end else begin
                    checkOutput("wdata", 64'(wdata), 64'(w_q[0]));
                    if (wready) begin
                        void'(w_q.pop_front());
                        w_hs_count++;
                    end
                end
            end
            if (bready) begin
                bready_cycles++;
                if (bvalid) b_hs_count++;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(rsp_q.size()), 64'd1);
                end else begin
                    rsp_item_t item;
                    item = rsp_q.pop_front();
                    checkOutput("rsp_resp", 64'(rsp_resp), 64'(item.resp));
                    checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(item.timeout));
                    checkOutput("rsp_latency", 64'(edge_count - accept_edge), 64'(item.latency));
                    checkOutput("cmd_ready_with_rsp", 64'(cmd_ready), 64'd1);
                end
            end
        end
    end

    // Runs one write against a slave with the given delays; never_b models a dead slave.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input int awd, input int wd, input int bd,
                                 input logic [1:0] resp, input bit never_b, input bit pulses);
        rsp_item_t item;
        int        exp_bready;
        int        waited;
        aw_delay   = awd;
        w_delay    = wd;
        b_delay    = bd;
        b_never    = never_b;
        b_resp_cfg = resp;
        if (never_b) begin
            item.resp    = 2'b10;
            item.timeout = 1'b1;
            item.latency = TIMEOUT + 1;
            exp_bready   = TIMEOUT - 1;
        end else begin
            item.resp    = resp;
            item.timeout = 1'b0;
            item.latency = ((awd > wd) ? awd : wd) + bd + 3;
            exp_bready   = bd + 1;
        end

        waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        aw_cycles = 0;
        w_cycles = 0;
        bready_cycles = 0;
        aw_hs_count = 0;
        w_hs_count = 0;
        b_hs_count = 0;
        aw_q.push_back(addr);
        w_q.push_back(data);
        rsp_q.push_back(item);
        cmd_addr    = addr;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        accept_edge = edge_count + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (pulses) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                cmd_addr  = 32'hDEAD_0000 + 32'(i);
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        end

        waited = 0;
        while (rsp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wait_rsp", 64'(rsp_q.size()), 64'd0);
        @(negedge clk);
        checkOutput("awvalid_cycles", 64'(aw_cycles), 64'(awd + 1));
        checkOutput("wvalid_cycles", 64'(w_cycles), 64'(wd + 1));
        checkOutput("bready_cycles", 64'(bready_cycles), 64'(exp_bready));
        checkOutput("aw_handshakes", 64'(aw_hs_count), 64'd1);
        checkOutput("w_handshakes", 64'(w_hs_count), 64'd1);
        checkOutput("b_handshakes", 64'(b_hs_count), never_b ? 64'd0 : 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("reset_awvalid", 64'(awvalid), 64'd0);
        checkOutput("reset_wvalid", 64'(wvalid), 64'd0);
        checkOutput("reset_bready", 64'(bready), 64'd0);
        checkOutput("reset_awaddr", 64'(awaddr), 64'd0);
        checkOutput("reset_wdata", 64'(wdata), 64'd0);
        checkOutput("reset_rsp", 64'({rsp_valid, rsp_resp, rsp_timeout}), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("release_cmd_ready_high", 64'(cmd_ready), 64'd1);

        $display("[TB] always-ready slave");
        applyStimulus(32'h0, 32'h02E9_0EDD, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        $display("[TB] delayed awready");
        applyStimulus(32'h4, 32'd10, 3, 0, 0, 2'b00, 1'b0, 1'b0);
        $display("[TB] delayed wready and bvalid, SLVERR, ignored cmd pulses");
        applyStimulus(32'h10, 32'h1234_5678, 2, 5, 2, 2'b10, 1'b0, 1'b1);
        $display("[TB] EXOKAY and DECERR passthrough");
        applyStimulus(32'h14, 32'hA5A5_A5A5, 1, 1, 1, 2'b01, 1'b0, 1'b0);
        applyStimulus(32'h18, 32'h5A5A_5A5A, 0, 2, 0, 2'b11, 1'b0, 1'b0);
        $display("[TB] response timeout");
        applyStimulus(32'h20, 32'hFFFF_0000, 0, 0, 0, 2'b00, 1'b1, 1'b0);
        applyStimulus(32'hC, 32'd5000, 0, 0, 0, 2'b00, 1'b0, 1'b0);

        $display("[TB] reset mid-transaction");
        aw_delay = 20;
        w_delay  = 20;
        b_never  = 1'b0;
        @(negedge clk);
        checkOutput("rst_test_cmd_ready", 64'(cmd_ready), 64'd1);
        aw_q.push_back(32'h8000_0000);
        w_q.push_back(32'hCAFE_F00D);
        cmd_addr  = 32'h8000_0000;
        cmd_data  = 32'hCAFE_F00D;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_awvalid", 64'(awvalid), 64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_awvalid", 64'(awvalid), 64'd0);
        checkOutput("async_wvalid", 64'(wvalid), 64'd0);
        checkOutput("async_bready", 64'(bready), 64'd0);
        aw_q.delete();
        w_q.delete();
        repeat (3) @(negedge clk);
        aw_delay = 0;
        w_delay  = 0;
        rst_n    = 1'b1;
        #1;
        checkOutput("rerelease_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rerelease_cmd_ready_high", 64'(cmd_ready), 64'd1);
        repeat (5) @(negedge clk);
        applyStimulus(32'h8, 32'd10000, 0, 0, 0, 2'b00, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got %0d expected completion", edge_count);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
